// File: rtl/upper_layer_lane_adapter_pkg.sv
// Shared types for the upper-layer lane adapter: link generation, link phase codes,
// adapter states and the generation-to-pacing-divider mapping.
package upper_layer_pkg;

    typedef enum logic [1:0] {
        GEN2 = 2'd0,
        GEN3 = 2'd1,
        GEN4 = 2'd2
    } gen_e;

    localparam logic [2:0] PHASE_DISABLED = 3'd0;
    localparam logic [2:0] PHASE_ACTIVE   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } adapter_state_e;

    // Encoding 3 is not a named generation and runs at the GEN4 rate.
    function automatic logic [2:0] pace_div(input gen_e gen);
        case (gen)
            GEN2:    return 3'd4;
            GEN3:    return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/upper_layer_lane_adapter_if.sv
// Transport-side handshake and lane-side beat bundle of the upper-layer lane adapter.
// The slave modport is the adapter's view; master is the surrounding logic's view.
interface upper_layer_lane_adapter_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 2,
    parameter int DEPTH  = 16
);
    logic [DATA_W-1:0]          transport_layer_data_in;
    logic                       enable_sending;
    logic                       in_ready;
    logic [LANES*DATA_W-1:0]    lane_data;
    logic                       lane_valid;
    logic [$clog2(DEPTH+1)-1:0] fifo_level;

    modport master (
        output transport_layer_data_in,
        output enable_sending,
        input  in_ready,
        input  lane_data,
        input  lane_valid,
        input  fifo_level
    );

    modport slave (
        input  transport_layer_data_in,
        input  enable_sending,
        output in_ready,
        output lane_data,
        output lane_valid,
        output fifo_level
    );
endinterface

// File: rtl/upper_layer_lane_adapter_fifo.sv
// Word FIFO for the lane adapter: one push per cycle, LANES words popped at once,
// occupancy output and a synchronous flush that overrides any same-cycle push or pop.
module upper_layer_fifo
    import upper_layer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 2,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [LANES*DATA_W-1:0]    pop_data,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(LANES);
            end
            level <= level + LVL_W'(push) - (pop ? LVL_W'(LANES) : '0);
        end
    end

    // Oldest word lands in lane 0; pointer arithmetic wraps naturally at DEPTH.
    always_comb begin
        pop_data = '0;
        for (int k = 0; k < LANES; k++) begin
            pop_data[k*DATA_W +: DATA_W] = mem[rd_ptr + PTR_W'(k)];
        end
    end

endmodule

// File: rtl/upper_layer_lane_adapter.sv
// Transport-to-lane transmit adapter: buffers transport words and releases LANES-wide
// beats paced by link generation. Optional macro UPPER_LAYER_ADAPTER_STATS_EN adds counters.
module upper_layer_lane_adapter
    import upper_layer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 2,
    parameter int DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  generation_speed,
    input  logic [2:0]                  phase,
    upper_layer_lane_adapter_if.slave   bus
`ifdef UPPER_LAYER_ADAPTER_STATS_EN
    ,
    output logic [15:0]                 beat_count,
    output logic [15:0]                 stall_count
`endif
);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] BEAT_WORDS = LVL_W'(LANES);

    adapter_state_e          state;
    adapter_state_e          state_next;
    logic [1:0]              pace_cnt;
    logic                    in_ready_c;
    logic                    push;
    logic                    pop;
    logic                    tick;
    logic                    flush;
    logic [LVL_W-1:0]        level;
    logic [LANES*DATA_W-1:0] pop_data;
    logic [LANES*DATA_W-1:0] lane_data_q;
    logic                    lane_valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The flush also fires on the cycle phase drops to 0, so a same-cycle push is lost.
    always_comb begin
        state_next = S_PAUSE;
        in_ready_c = 1'b0;
        push       = 1'b0;
        tick       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;

        if (phase == PHASE_DISABLED) begin
            state_next = S_IDLE;
        end else if (phase == PHASE_ACTIVE) begin
            state_next = S_RUN;
        end

        in_ready_c = (state != S_IDLE) && (level != FULL_LEVEL);
        push       = bus.enable_sending && in_ready_c;
        tick       = (state == S_RUN) && (pace_cnt == 2'd0);
        pop        = tick && (level >= BEAT_WORDS);
        flush      = (state == S_IDLE) || (state_next == S_IDLE);
    end

    // Generation is sampled only on reload, so a change waits for the current interval.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pace_cnt <= 2'd0;
        end else begin
            case (state)
                S_IDLE:  pace_cnt <= 2'd0;
                S_RUN:   pace_cnt <= tick ? 2'(pace_div(gen_e'(generation_speed)) - 3'd1)
                                          : pace_cnt - 2'd1;
                default: pace_cnt <= pace_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_valid_q <= 1'b0;
            lane_data_q  <= '0;
        end else begin
            lane_valid_q <= pop;
            if (pop) begin
                lane_data_q <= pop_data;
            end
        end
    end

    upper_layer_fifo #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (bus.transport_layer_data_in),
        .pop       (pop),
        .pop_data  (pop_data),
        .level     (level)
    );

    assign bus.in_ready   = in_ready_c;
    assign bus.lane_valid = lane_valid_q;
    assign bus.lane_data  = lane_data_q;
    assign bus.fifo_level = level;

`ifdef UPPER_LAYER_ADAPTER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_count  <= 16'd0;
            stall_count <= 16'd0;
        end else if (state == S_IDLE) begin
            beat_count  <= 16'd0;
            stall_count <= 16'd0;
        end else begin
            if (lane_valid_q && (beat_count != 16'hFFFF)) begin
                beat_count <= beat_count + 16'd1;
            end
            if (tick && (level < BEAT_WORDS) && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule
